// File: rtl/led_pkg.sv
// led_pkg: shared FSM encoding, width helpers and default timing for the LED code sequencer
package led_pkg;

    typedef enum logic [2:0] {IDLE, ON, OFF, GAP, FIN} state_t;

    localparam int DEF_TICK_CYCLES = 250;
    localparam int DEF_ON_TICKS    = 2;
    localparam int DEF_OFF_TICKS   = 2;
    localparam int DEF_GAP_TICKS   = 8;

    function automatic int clogb2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int TICK_W  = clogb2(DEF_TICK_CYCLES);
    localparam int PHASE_W = clogb2(max3(DEF_ON_TICKS, DEF_OFF_TICKS, DEF_GAP_TICKS));

endpackage

// File: rtl/led_code_sequencer_if.sv
// led_code_sequencer_if: request/code/grant/done bundle between status sources and the LED sequencer
interface led_code_sequencer_if #(
    parameter int NUM_REQ    = 4,
    parameter int CODE_WIDTH = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*CODE_WIDTH-1:0] code;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic                          busy;
    logic                          led_out;

    modport master (output req, code, input grant, done, busy, led_out);
    modport slave  (input req, code, output grant, done, busy, led_out);
endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler giving a one-cycle tick every TICK_CYCLES clocks, held at zero by clr
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CNT_W = clogb2(TICK_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == CNT_W'(TICK_CYCLES - 1));

    // free-running 0..TICK_CYCLES-1 counter, cleared while the sequencer is idle
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_cnt <= '0;
        else                r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/led_code_sequencer.sv
// led_code_sequencer: arbitrates requesters onto one LED and blinks each winner's numeric code
// Optional macro LED_CODE_RR_EN selects round-robin arbitration instead of fixed priority.
module led_code_sequencer
    import led_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CODE_WIDTH  = 4,
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int ON_TICKS    = DEF_ON_TICKS,
    parameter int OFF_TICKS   = DEF_OFF_TICKS,
    parameter int GAP_TICKS   = DEF_GAP_TICKS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    led_code_sequencer_if.slave   io_bus
);
    localparam int PH_W = clogb2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS));
    localparam int IX_W = clogb2(NUM_REQ);

    state_t                r_state, w_state_nxt;
    logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]    r_done, w_done_nxt;
    logic                  r_led, w_led_nxt;
    logic [CODE_WIDTH-1:0] r_pulses, w_pulses_nxt;
    logic [PH_W-1:0]       r_phase, w_phase_nxt;
    logic [PH_W-1:0]       w_limit;
    logic [CODE_WIDTH-1:0] w_code;
    logic [IX_W-1:0]       w_win;
    logic                  w_tick, w_any, w_phase_end;

    led_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (r_state == IDLE),
        .o_tick (w_tick)
    );

    assign w_any          = |io_bus.req;
    assign w_code         = io_bus.code[int'(w_win)*CODE_WIDTH +: CODE_WIDTH];
    assign w_limit        = (r_state == ON)  ? PH_W'(ON_TICKS - 1)  :
                            (r_state == OFF) ? PH_W'(OFF_TICKS - 1) : PH_W'(GAP_TICKS - 1);
    assign w_phase_end    = w_tick && (r_phase == w_limit);
    assign io_bus.grant   = r_grant;
    assign io_bus.done    = r_done;
    assign io_bus.busy    = (r_state != IDLE);
    assign io_bus.led_out = r_led;

`ifdef LED_CODE_RR_EN
    logic [IX_W-1:0] r_ptr;

    // search start moves just past each winner so held requests take turns
    always_ff @(posedge i_clk) begin
        if (i_rst)                          r_ptr <= '0;
        else if (r_state == IDLE && w_any)  r_ptr <= (w_win == IX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end

    // round-robin winner: first requesting index at or after the pointer
    always_comb begin
        int j;
        j = 0;
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (io_bus.req[j]) w_win = IX_W'(j);
        end
    end
`else
    // fixed priority winner: lowest requesting index
    always_comb begin
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (io_bus.req[k]) w_win = IX_W'(k);
    end
`endif

    // state and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_led    <= 1'b0;
            r_pulses <= '0;
            r_phase  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_done   <= w_done_nxt;
            r_led    <= w_led_nxt;
            r_pulses <= w_pulses_nxt;
            r_phase  <= w_phase_nxt;
        end
    end

    // next state: latch code on grant, then walk ON/OFF pulses, the gap and the completion cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_done_nxt   = '0;
        w_led_nxt    = r_led;
        w_pulses_nxt = r_pulses;
        w_phase_nxt  = (r_state == IDLE || r_state == FIN) ? '0 :
                       w_phase_end ? '0 : w_tick ? r_phase + 1'b1 : r_phase;
        case (r_state)
            IDLE: if (w_any) begin
                w_grant_nxt  = NUM_REQ'(1) << w_win;
                w_pulses_nxt = w_code;
                w_led_nxt    = (w_code != '0);
                w_state_nxt  = (w_code != '0) ? ON : FIN;
            end
            ON: if (w_phase_end) begin
                w_led_nxt    = 1'b0;
                w_pulses_nxt = r_pulses - 1'b1;
                w_state_nxt  = OFF;
            end
            OFF: if (w_phase_end) begin
                w_led_nxt   = (r_pulses != '0);
                w_state_nxt = (r_pulses != '0) ? ON : GAP;
            end
            GAP: if (w_phase_end) w_state_nxt = FIN;
            FIN: begin
                w_done_nxt  = r_grant;
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_led_code_sequencer.sv
// tb_led_code_sequencer: randomized self-checking bench against a timing-formula model of the LED code sequencer
module tb_led_code_sequencer;
    localparam int NR = 4, CW = 4, T = 4, ONT = 2, OFFT = 2, GAPT = 8;
    localparam int P = ONT + OFFT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_pass = 0;
    int   m_ptr = 0;
    bit   led_q[$], busy_q[$];
    logic [NR-1:0] grant_q[$];

    always #5 clk = ~clk;

    led_code_sequencer_if #(.NUM_REQ(NR), .CODE_WIDTH(CW)) bus ();

    led_code_sequencer #(
        .NUM_REQ(NR), .CODE_WIDTH(CW), .TICK_CYCLES(T),
        .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.slave)
    );

    function automatic int exp_done_off(int n);
        return (n == 0) ? 1 : (n * P + GAPT) * T + 1;
    endfunction

    function automatic bit exp_led(int n, int t);
        return (n > 0) && (t < n * P * T) && ((t % (P * T)) < ONT * T);
    endfunction

    function automatic int exp_winner(logic [NR-1:0] r, int ptr);
`ifdef LED_CODE_RR_EN
        for (int k = 0; k < NR; k++) if (r[(ptr + k) % NR]) return (ptr + k) % NR;
`else
        for (int k = 0; k < NR; k++) if (r[k] && ptr >= 0) return k;
`endif
        return -1;
    endfunction

    function automatic int code_of(logic [NR*CW-1:0] c, int i);
        logic [NR*CW-1:0] s;
        s = c >> (i * CW);
        return int'(s[CW-1:0]);
    endfunction

    function automatic int trace_errs(int n, int w);
        int e, d;
        logic [NR-1:0] g;
        e = 0;
        d = exp_done_off(n);
        g = (w >= 0) ? NR'(1) << w : '0;
        if (led_q.size() != d + 1) e++;
        for (int t = 0; t < led_q.size(); t++) begin
            if (led_q[t] !== exp_led(n, t)) e++;
            if (busy_q[t] !== (t < d)) e++;
            if (grant_q[t] !== ((t < d) ? g : '0)) e++;
        end
        return e;
    endfunction

    task automatic watch(output logic [NR-1:0] g, output int wait_n, output int done_off, output logic [NR-1:0] d);
        g = '0; d = '0; done_off = -1;
        led_q.delete(); busy_q.delete(); grant_q.delete();
        for (wait_n = 0; wait_n < 10 && bus.grant == '0; wait_n++) @(negedge clk);
        g = bus.grant;
        if (g == '0) return;
        for (int t = 0; t < 2000; t++) begin
            led_q.push_back(bus.led_out);
            busy_q.push_back(bus.busy);
            grant_q.push_back(bus.grant);
            if (bus.done != '0) begin
                done_off = t;
                d = bus.done;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = '0; bus.code = '0; m_ptr = 0;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.grant !== '0) $display("FAIL reset_grant: got %b want 0", bus.grant); else n_pass++;
        n_chk++; if (bus.done !== '0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_chk++; if (bus.led_out !== 1'b0) $display("FAIL reset_led: got %b want 0", bus.led_out); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [NR-1:0] g, d;
        int wn, doff, w;
        bus.code = 16'h0003; bus.req = 4'b0001;
        w = exp_winner(bus.req, m_ptr);
        watch(g, wn, doff, d);
        bus.req = '0; m_ptr = (w + 1) % NR;
        n_chk++; if (g !== 4'b0001) $display("FAIL basic_grant: got %b want 0001", g); else n_pass++;
        n_chk++; if (wn !== 1) $display("FAIL basic_latency: got %0d want 1", wn); else n_pass++;
        n_chk++; if (doff !== 81) $display("FAIL basic_done_off: got %0d want 81", doff); else n_pass++;
        n_chk++; if (d !== 4'b0001) $display("FAIL basic_done_vec: got %b want 0001", d); else n_pass++;
        n_chk++; if (trace_errs(3, w) !== 0) $display("FAIL basic_trace: got %0d bad cycles want 0", trace_errs(3, w)); else n_pass++;
    endtask

    task automatic test_priority();
        logic [NR-1:0] g, d;
        int wn, doff, w;
        bus.code = 16'h0210; bus.req = 4'b0110;
        w = exp_winner(bus.req, m_ptr);
        watch(g, wn, doff, d);
        m_ptr = (w + 1) % NR;
        bus.req[w] = 1'b0;
        n_chk++; if (g !== NR'(1) << w) $display("FAIL prio_first: got %b want %0d", g, w); else n_pass++;
        n_chk++; if (doff !== exp_done_off(code_of(bus.code, w))) $display("FAIL prio_first_done: got %0d want %0d", doff, exp_done_off(code_of(bus.code, w))); else n_pass++;
        w = exp_winner(bus.req, m_ptr);
        watch(g, wn, doff, d);
        bus.req = '0; m_ptr = (w + 1) % NR;
        n_chk++; if (g !== 4'b0100) $display("FAIL prio_second: got %b want 0100", g); else n_pass++;
        n_chk++; if (wn !== 1) $display("FAIL prio_idle_gap: got %0d want 1", wn); else n_pass++;
        n_chk++; if (trace_errs(2, w) !== 0) $display("FAIL prio_second_trace: got %0d bad cycles want 0", trace_errs(2, w)); else n_pass++;
    endtask

    task automatic test_held_all();
        logic [NR-1:0] g, d;
        int wn, doff, w;
        bus.code = 16'h1111; bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            w = exp_winner(bus.req, m_ptr);
            watch(g, wn, doff, d);
            m_ptr = (w + 1) % NR;
            n_chk++; if (g !== NR'(1) << w) $display("FAIL held_round%0d_grant: got %b want idx %0d", r, g, w); else n_pass++;
            n_chk++; if (wn !== 1) $display("FAIL held_round%0d_gap: got %0d want 1", r, wn); else n_pass++;
            n_chk++; if (d !== NR'(1) << w) $display("FAIL held_round%0d_done: got %b want idx %0d", r, d, w); else n_pass++;
        end
        bus.req = '0;
    endtask

    task automatic test_code_zero();
        logic [NR-1:0] g, d;
        int wn, doff;
        bus.code = 16'h5550; bus.req = 4'b0001;
        watch(g, wn, doff, d);
        bus.req = '0; m_ptr = 1;
        n_chk++; if (g !== 4'b0001) $display("FAIL zero_grant: got %b want 0001", g); else n_pass++;
        n_chk++; if (wn + doff !== 2) $display("FAIL zero_total: got %0d want 2", wn + doff); else n_pass++;
        n_chk++; if (d !== 4'b0001) $display("FAIL zero_done: got %b want 0001", d); else n_pass++;
        n_chk++; if (trace_errs(0, 0) !== 0) $display("FAIL zero_trace: got %0d bad cycles want 0", trace_errs(0, 0)); else n_pass++;
    endtask

    task automatic test_mid_change();
        logic [NR-1:0] g, d;
        int wn, doff;
        bus.code = 16'h0003; bus.req = 4'b0001;
        fork
            watch(g, wn, doff, d);
            begin
                repeat (20) @(negedge clk);
                bus.req = '0; bus.code = 16'h0007;
            end
        join
        m_ptr = 1;
        n_chk++; if (doff !== 81) $display("FAIL mid_done_off: got %0d want 81", doff); else n_pass++;
        n_chk++; if (d !== 4'b0001) $display("FAIL mid_done_vec: got %b want 0001", d); else n_pass++;
        n_chk++; if (trace_errs(3, 0) !== 0) $display("FAIL mid_trace: got %0d bad cycles want 0", trace_errs(3, 0)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] g, d;
        int wn, doff, n_done;
        bus.code = 16'h0003; bus.req = 4'b0001;
        repeat (7) @(negedge clk);
        n_chk++; if (bus.led_out !== 1'b1) $display("FAIL rstmid_led_before: got %b want 1", bus.led_out); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if ({bus.grant, bus.done, bus.busy, bus.led_out} !== '0) $display("FAIL rstmid_outputs: got %b want 0", {bus.grant, bus.done, bus.busy, bus.led_out}); else n_pass++;
        rst = 1'b0; bus.req = '0; m_ptr = 0;
        n_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.done != '0 || bus.busy) n_done++;
        end
        n_chk++; if (n_done !== 0) $display("FAIL rstmid_no_done: got %0d active cycles want 0", n_done); else n_pass++;
        bus.req = 4'b0001;
        watch(g, wn, doff, d);
        bus.req = '0; m_ptr = 1;
        n_chk++; if (doff !== 81) $display("FAIL rstmid_restart_done: got %0d want 81", doff); else n_pass++;
        n_chk++; if (trace_errs(3, 0) !== 0) $display("FAIL rstmid_restart_trace: got %0d bad cycles want 0", trace_errs(3, 0)); else n_pass++;
    endtask

    task automatic test_random();
        logic [NR-1:0] g, d;
        int wn, doff, w, n;
        for (int r = 0; r < 8; r++) begin
            bus.req = NR'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) bus.code[i*CW +: CW] = CW'($urandom_range(0, 3));
            w = exp_winner(bus.req, m_ptr);
            n = code_of(bus.code, w);
            watch(g, wn, doff, d);
            bus.req = '0; m_ptr = (w + 1) % NR;
            n_chk++; if (g !== NR'(1) << w) $display("FAIL rand%0d_grant: got %b want idx %0d", r, g, w); else n_pass++;
            n_chk++; if (doff !== exp_done_off(n)) $display("FAIL rand%0d_done_off: got %0d want %0d", r, doff, exp_done_off(n)); else n_pass++;
            n_chk++; if (d !== NR'(1) << w) $display("FAIL rand%0d_done_vec: got %b want idx %0d", r, d, w); else n_pass++;
            n_chk++; if (trace_errs(n, w) !== 0) $display("FAIL rand%0d_trace: got %0d bad cycles want 0", r, trace_errs(n, w)); else n_pass++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        bus.req = '0;
        bus.code = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_priority();
        test_held_all();
        test_code_zero();
        test_mid_change();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
